// File: rtl/pmc_pkg.sv
// Shared definitions for the program-memory controller: FSM states,
// default widths and the index-width helper.
package pmc_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        READ_WAITING = 2'd1,
        RELAYING     = 2'd2
    } pmc_state_t;

    localparam int PMC_ADDR_BITS     = 8;
    localparam int PMC_DATA_BITS     = 16;
    localparam int PMC_NUM_CONSUMERS = 4;

    // A single consumer still needs a one-bit index to keep port widths legal.
    function automatic int idx_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin selector: picks the first requester at or after ptr,
// returning both a one-hot grant and its index.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx
);

    logic [IDX_W-1:0] pos;

    // Scan from the farthest offset down so the nearest requester to ptr wins last.
    always_comb begin
        grant = '0;
        idx   = '0;
        pos   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            pos = IDX_W'((int'(ptr) + i) % N);
            if (req[pos]) begin
                grant      = '0;
                grant[pos] = 1'b1;
                idx        = pos;
            end
        end
    end

endmodule

// File: rtl/program_mem_controller.sv
// Shares one external program memory among several instruction fetchers.
// Optional one-entry hit buffer enabled by defining PMC_HIT_BUFFER_EN.
module program_mem_controller
    import pmc_pkg::*;
#(
    parameter int ADDR_BITS     = PMC_ADDR_BITS,
    parameter int DATA_BITS     = PMC_DATA_BITS,
    parameter int NUM_CONSUMERS = PMC_NUM_CONSUMERS
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic [NUM_CONSUMERS-1:0]                 consumer_read_valid,
    input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0]  consumer_read_address,
    output logic [NUM_CONSUMERS-1:0]                 consumer_read_ready,
    output logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]  consumer_read_data,
    output logic                                     mem_read_valid,
    output logic [ADDR_BITS-1:0]                     mem_read_address,
    input  logic                                     mem_read_ready,
    input  logic [DATA_BITS-1:0]                     mem_read_data
);

    localparam int IDX_W = idx_bits(NUM_CONSUMERS);

    pmc_state_t               state_q, state_d;
    logic [IDX_W-1:0]         ptr_q, winner_q, grant_idx, ptr_next;
    logic [NUM_CONSUMERS-1:0] grant_oh, winner_oh_q;
    logic                     any_req, hit, grant_fire, mem_done;

    rr_arbiter #(
        .N     (NUM_CONSUMERS),
        .IDX_W (IDX_W)
    ) u_arbiter (
        .req   (consumer_read_valid),
        .ptr   (ptr_q),
        .grant (grant_oh),
        .idx   (grant_idx)
    );

    assign any_req    = |consumer_read_valid;
    assign grant_fire = (state_q == IDLE) && any_req;
    assign mem_done   = (state_q == READ_WAITING) && mem_read_ready;
    assign ptr_next   = (grant_idx == IDX_W'(NUM_CONSUMERS - 1)) ? '0 : grant_idx + IDX_W'(1);

`ifdef PMC_HIT_BUFFER_EN
    logic                 hb_valid_q;
    logic [ADDR_BITS-1:0] hb_addr_q;
    logic [DATA_BITS-1:0] hb_data_q;

    assign hit = hb_valid_q && (consumer_read_address[grant_idx] == hb_addr_q);

    // Remembers the most recent completed memory read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hb_valid_q <= 1'b0;
            hb_addr_q  <= '0;
            hb_data_q  <= '0;
        end else if (mem_done) begin
            hb_valid_q <= 1'b1;
            hb_addr_q  <= mem_read_address;
            hb_data_q  <= mem_read_data;
        end
    end
`else
    assign hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:         if (any_req) state_d = hit ? RELAYING : READ_WAITING;
            READ_WAITING: if (mem_read_ready) state_d = RELAYING;
            RELAYING:     if (!consumer_read_valid[winner_q]) state_d = IDLE;
            default:      state_d = IDLE;
        endcase
    end

    // Handshake outputs follow the state directly, so reset clears them at once.
    always_comb begin
        mem_read_valid      = (state_q == READ_WAITING);
        consumer_read_ready = (state_q == RELAYING) ? winner_oh_q : '0;
    end

    // Winner and address are frozen at grant; later address changes are ignored.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q              <= '0;
            winner_q           <= '0;
            winner_oh_q        <= '0;
            mem_read_address   <= '0;
            consumer_read_data <= '0;
        end else begin
            if (grant_fire) begin
                ptr_q            <= ptr_next;
                winner_q         <= grant_idx;
                winner_oh_q      <= grant_oh;
                mem_read_address <= consumer_read_address[grant_idx];
`ifdef PMC_HIT_BUFFER_EN
                if (hit) consumer_read_data[grant_idx] <= hb_data_q;
`endif
            end
            if (mem_done) begin
                consumer_read_data[winner_q] <= mem_read_data;
            end
        end
    end

endmodule

// File: tb/tb_program_mem_controller.sv
// Self-checking bench for program_mem_controller: directed table, hand-written
// corner sequences and a randomized run against a transaction-level model.
module tb_program_mem_controller;

    localparam int N  = 4;
    localparam int AW = 8;
    localparam int DW = 16;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [N-1:0]         cv;
    logic [N-1:0][AW-1:0] ca;
    logic [N-1:0]         crr;
    logic [N-1:0][DW-1:0] crd;
    logic                 mrv;
    logic [AW-1:0]        mra;
    logic                 mrr;
    logic [DW-1:0]        mrd;

    always #5 clk = ~clk;

    program_mem_controller #(
        .ADDR_BITS     (AW),
        .DATA_BITS     (DW),
        .NUM_CONSUMERS (N)
    ) dut (
        .clk                   (clk),
        .reset                 (reset),
        .consumer_read_valid   (cv),
        .consumer_read_address (ca),
        .consumer_read_ready   (crr),
        .consumer_read_data    (crd),
        .mem_read_valid        (mrv),
        .mem_read_address      (mra),
        .mem_read_ready        (mrr),
        .mem_read_data         (mrd)
    );

    int            checks = 0;
    int            fails  = 0;
    int            mem_wait = 0;
    int            mem_cnt  = 0;
    bit            mem_auto = 1'b1;
    bit            mem_rand = 1'b0;
    bit            prev_mv  = 1'b0;
    logic [AW-1:0] reads[$];
    logic [DW-1:0] last_data [N];
    int            m_ptr = 0;

    typedef struct {
        int            c;
        logic [AW-1:0] addr;
        int            wait_c;
        int            hold;
        logic [DW-1:0] exp_data;
        int            exp_lat;
    } vec_t;

    vec_t tbl [5];

    // Memory contents: fixed value at 0x12, otherwise {addr^0x5A, ~addr}.
    function automatic logic [DW-1:0] memfun(input logic [AW-1:0] a);
        if (a == 8'h12) return 16'hA5A5;
        return {a ^ 8'h5A, ~a};
    endfunction

    function automatic logic [N-1:0] onehot(input int i);
        logic [N-1:0] v;
        v = '0;
        v[2'(i)] = 1'b1;
        return v;
    endfunction

    function automatic int rr_pick(input logic [N-1:0] req, input int ptr);
        for (int i = 0; i < N; i++) begin
            if (req[2'((ptr + i) % N)]) return (ptr + i) % N;
        end
        return 0;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    // One clock: advance to the next falling edge, then play the memory side.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        if (mrv && !prev_mv) begin
            reads.push_back(mra);
            mem_cnt = 0;
            if (mem_rand) mem_wait = $urandom_range(0, 3);
        end
        prev_mv = mrv;
        if (mem_auto) begin
            if (mrv) begin
                if (mem_cnt >= mem_wait) begin
                    mrr = 1'b1;
                    mrd = memfun(mra);
                end else begin
                    mrr = 1'b0;
                    mem_cnt++;
                end
            end else begin
                mrr = 1'b0;
                mrd = 16'($urandom);
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cv    = '0;
        mrr   = 1'b0;
        #1;
        check("rst_mem_valid", mrv, 0);
        check("rst_mem_addr", mra, 0);
        check("rst_ready", crr, 0);
        check("rst_data", crd, 0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < N; i++) last_data[i] = '0;
        m_ptr   = 0;
        prev_mv = 1'b0;
    endtask

    task automatic run_row(input vec_t v);
        int lat;
        bit got;
        lat = 0;
        got = 1'b0;
        mem_wait = v.wait_c;
        ca[2'(v.c)] = v.addr;
        cv[2'(v.c)] = 1'b1;
        while (!got && lat < 40) begin
            tick();
            lat++;
            if (mrv) check("row_mem_addr", mra, v.addr);
            if (crr != '0) got = 1'b1;
        end
        check("row_latency", lat, v.exp_lat);
        check("row_ready", crr, onehot(v.c));
        check("row_data", crd[2'(v.c)], v.exp_data);
        last_data[v.c] = v.exp_data;
        for (int k = 0; k < v.hold; k++) begin
            tick();
            check("row_hold_ready", crr, onehot(v.c));
            check("row_hold_no_mem", mrv, 0);
        end
        cv[2'(v.c)] = 1'b0;
        tick();
        check("row_release", crr, 0);
        for (int i = 0; i < N; i++) check("row_data_retain", crd[2'(i)], last_data[i]);
    endtask

    task automatic reset_mid_read();
        mem_auto = 1'b0;
        ca[1] = 8'h33;
        cv    = onehot(1);
        tick();
        tick();
        check("rw_mem_valid", mrv, 1);
        check("rw_mem_addr", mra, 8'h33);
        do_reset();
        mrr = 1'b1;
        mrd = 16'hBEEF;
        tick();
        mrr = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("late_ready_ignored", crr, 0);
            check("late_no_mem", mrv, 0);
        end
        mem_auto = 1'b1;
    endtask

    task automatic burst();
        int order[$];
        int t;
        t = 0;
        mem_wait = 1;
        reads.delete();
        for (int i = 0; i < N; i++) ca[2'(i)] = 8'(i);
        cv = '1;
        while (t < 300) begin
            tick();
            t++;
            for (int i = 0; i < N; i++) begin
                if (crr[2'(i)] && cv[2'(i)]) begin
                    order.push_back(i);
                    check("burst_data", crd[2'(i)], memfun(8'(i)));
                    last_data[i] = memfun(8'(i));
                    cv[2'(i)] = 1'b0;
                end else if (!cv[2'(i)] && !crr[2'(i)] && order.size() < 5) begin
                    cv[2'(i)] = 1'b1;
                end
            end
            check("burst_one_ready", $countones(crr) <= 1, 1);
            if (order.size() >= 5 && cv == '0 && crr == '0 && !mrv) break;
        end
        check("burst_finished", t < 300, 1);
        check("burst_served", order.size() >= 5, 1);
        check("burst_reads", reads.size() >= 5, 1);
        if (order.size() >= 5 && reads.size() >= 5) begin
            for (int k = 0; k < 5; k++) begin
                check("burst_grant_order", order[k], k % N);
                check("burst_read_order", reads[k], 8'(k % N));
            end
        end
    endtask

    task automatic withdraw_after_grant();
        int t;
        t = 0;
        mem_wait = 2;
        ca[3] = 8'h21;
        cv    = onehot(3);
        tick();
        check("wd_mem_valid", mrv, 1);
        check("wd_mem_addr", mra, 8'h21);
        ca[3] = 8'h99;
        cv    = '0;
        while (crr == '0 && t < 20) begin
            tick();
            t++;
            if (mrv) check("wd_addr_stable", mra, 8'h21);
        end
        check("wd_ready", crr, onehot(3));
        check("wd_data", crd[3], 16'h7BDE);
        last_data[3] = 16'h7BDE;
        tick();
        check("wd_ready_cleared", crr, 0);
    endtask

    task automatic shared_address();
        int t, t1, t2;
        t  = 0;
        t1 = -1;
        t2 = -1;
        mem_wait = 0;
        reads.delete();
        ca[1] = 8'h40;
        ca[2] = 8'h40;
        cv    = 4'b0110;
        while (t < 60 && t2 < 0) begin
            tick();
            t++;
            if (crr[1] && cv[1]) begin
                check("shared_data1", crd[1], 16'h1ABF);
                t1 = t;
                cv[1] = 1'b0;
            end
            if (crr[2] && cv[2]) begin
                check("shared_data2", crd[2], 16'h1ABF);
                t2 = t;
                cv[2] = 1'b0;
            end
        end
        tick();
        check("shared_release", crr, 0);
`ifdef PMC_HIT_BUFFER_EN
        check("shared_read_count", reads.size(), 1);
        check("shared_gap", t2 - t1, 2);
`else
        check("shared_read_count", reads.size(), 2);
        check("shared_gap", t2 - t1, 3);
`endif
    endtask

    task automatic random_run();
        int            phase, win, hold, busy_t;
        bit            seen;
        logic [AW-1:0] waddr;
        phase = 0; win = 0; hold = 0; busy_t = 0; seen = 1'b0; waddr = '0;
        mem_rand = 1'b1;
        for (int it = 0; it < 2000; it++) begin
            tick();
            check("rand_one_ready", $countones(crr) <= 1, 1);
            if (phase == 1) begin
                busy_t++;
                check("rand_ready_winner_only", crr & ~onehot(win), 0);
                if (mrv) check("rand_mem_addr", mra, waddr);
                if (crr[2'(win)] && !seen) begin
                    seen = 1'b1;
                    check("rand_data", crd[2'(win)], memfun(waddr));
                    last_data[win] = memfun(waddr);
                    hold = $urandom_range(0, 2);
                end
                if (busy_t > 60) begin
                    check("rand_timeout", busy_t, 0);
                    break;
                end
            end else begin
                check("rand_idle_ready", crr, 0);
                check("rand_idle_mem", mrv, 0);
                phase = 0;
            end
            for (int i = 0; i < N; i++) check("rand_data_retain", crd[2'(i)], last_data[i]);
            if (phase == 1 && seen) begin
                if (hold == 0) begin
                    cv[2'(win)] = 1'b0;
                    phase = 2;
                end else begin
                    hold--;
                end
            end
            if (it < 1800) begin
                for (int i = 0; i < N; i++) begin
                    if (!cv[2'(i)] && !(phase != 0 && i == win) && $urandom_range(0, 2) == 0) begin
                        ca[2'(i)] = 8'($urandom_range(64, 69));
                        cv[2'(i)] = 1'b1;
                    end
                end
            end
            if (phase == 0 && cv != '0) begin
                win    = rr_pick(cv, m_ptr);
                waddr  = ca[2'(win)];
                m_ptr  = (win + 1) % N;
                phase  = 1;
                seen   = 1'b0;
                busy_t = 0;
            end
        end
        check("rand_drained", phase, 0);
        check("rand_no_pending", cv, 0);
        mem_rand = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tbl[0] = '{0, 8'h12, 3, 1, 16'hA5A5, 5};
        tbl[1] = '{2, 8'h77, 0, 5, 16'h2D88, 2};
        tbl[2] = '{1, 8'hFF, 1, 0, 16'hA500, 3};
        tbl[3] = '{3, 8'h00, 2, 2, 16'h5AFF, 4};
        tbl[4] = '{0, 8'h80, 0, 0, 16'hDA7F, 2};

        reset = 1'b1;
        cv    = '0;
        ca    = '0;
        mrr   = 1'b0;
        mrd   = '0;
        @(negedge clk);
        do_reset();

        for (int r = 0; r < 5; r++) run_row(tbl[r]);
        reset_mid_read();
        burst();
        withdraw_after_grant();
        do_reset();
        shared_address();
        do_reset();
        random_run();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
